inst_sram_resp: RTL and testbench

INST_SRAM_RESP -- requirements
Module: inst_sram_resp

---
 rtl/inst_sram_resp.sv | 114 +++++++++++
 tb/tb_inst_sram_resp.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_sram_resp.sv
// Instruction SRAM with a streaming image loader; after loading, serves a
// single-cycle read/byte-write port with out-of-range detection.
module inst_sram_resp #(
  parameter int          DEPTH_LOG2 = 12,
  parameter logic [31:0] BASE       = 32'hbfc00000,
  parameter bit          LOAD_EN    = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_en,
  input  logic [3:0]  inst_sram_wen,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic [31:0] inst_sram_rdata,
  output logic        addr_err,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  input  logic        load_last,
  output logic        load_ready,
  output logic        load_done
);

  localparam int                    DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [32:0]           SPAN     = 33'd4 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] LAST_PTR = '1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;

  typedef enum logic {S_LOAD, S_READY} state_t;

  state_t                r_state;
  logic [DEPTH_LOG2-1:0] r_load_ptr;
  logic                  r_load_ready;
  logic                  r_load_done;
  logic [31:0]           r_rdata;
  logic                  r_addr_err;
  logic [31:0]           r_mem [DEPTH];

  logic [31:0]           w_offset;
  logic                  w_in_range;
  logic [DEPTH_LOG2-1:0] w_index;
  logic                  w_load_acc;
  logic                  w_port_we;

  // Subtraction wraps, so addresses below BASE land far out of range.
  assign w_offset   = inst_sram_addr - BASE;
  assign w_in_range = {1'b0, w_offset} < SPAN;
  assign w_index    = w_offset[DEPTH_LOG2+1:2];
  assign w_load_acc = !reset && (r_state == S_LOAD) && load_valid;
  assign w_port_we  = !reset && (r_state == S_READY) && inst_sram_en &&
                      w_in_range && (inst_sram_wen != 4'h0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= LOAD_EN ? S_LOAD : S_READY;
      r_load_ptr   <= '0;
      r_load_ready <= LOAD_EN;
      r_load_done  <= !LOAD_EN;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (load_valid) begin
            // Pointer saturates at the top word; the image ends there.
            if (load_last || r_load_ptr == LAST_PTR) begin
              r_state      <= S_READY;
              r_load_ready <= 1'b0;
              r_load_done  <= 1'b1;
            end else begin
              r_load_ptr <= r_load_ptr + PTR_ONE;
            end
          end
        end
        default: begin
          r_load_ready <= 1'b0;
          r_load_done  <= 1'b1;
        end
      endcase
    end
  end

  // Contents survive reset so a warm restart keeps the image.
  always_ff @(posedge clk) begin
    if (w_load_acc) begin
      r_mem[r_load_ptr] <= load_data;
    end else if (w_port_we) begin
      for (int i = 0; i < 4; i++) begin
        if (inst_sram_wen[i]) r_mem[w_index][8*i +: 8] <= inst_sram_wdata[8*i +: 8];
      end
    end
  end

  // Read-first: the read samples the array before this cycle's write lands.
  always_ff @(posedge clk) begin
    if (reset || r_state == S_LOAD) begin
      r_rdata    <= '0;
      r_addr_err <= 1'b0;
    end else if (inst_sram_en) begin
      if (w_in_range) begin
        r_rdata    <= r_mem[w_index];
        r_addr_err <= 1'b0;
      end else begin
        r_rdata    <= '0;
        r_addr_err <= 1'b1;
      end
    end else begin
      r_addr_err <= 1'b0;
    end
  end

  assign inst_sram_rdata = r_rdata;
  assign addr_err        = r_addr_err;
  assign load_ready      = r_load_ready;
  assign load_done       = r_load_done;

endmodule

// File: tb/tb_inst_sram_resp.sv
// Scoreboard bench for inst_sram_resp: a default-size instance driven through
// load/read/write/range cases, plus a 4-word instance for loader saturation.
module tb_inst_sram_resp;

  localparam logic [31:0] BASE = 32'hbfc00000;

  logic        clk, rst;
  logic        en, ld_v, ld_l;
  logic [3:0]  wen;
  logic [31:0] addr, wdata, ld_d;
  logic [31:0] rdata;
  logic        aerr, ld_rdy, ld_done;

  logic        s_en, s_ld_v;
  logic [31:0] s_addr, s_ld_d;
  logic [31:0] s_rdata;
  logic        s_aerr, s_ld_rdy, s_ld_done;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [31:0] rd; logic err; bit known; } exp_t;
  exp_t        sbq[$];
  logic [31:0] mdl [int];
  logic [31:0] last_rd;
  bit          last_known;

  inst_sram_resp dut (
    .clk(clk), .reset(rst),
    .inst_sram_en(en), .inst_sram_wen(wen), .inst_sram_addr(addr),
    .inst_sram_wdata(wdata), .inst_sram_rdata(rdata), .addr_err(aerr),
    .load_valid(ld_v), .load_data(ld_d), .load_last(ld_l),
    .load_ready(ld_rdy), .load_done(ld_done)
  );

  inst_sram_resp #(.DEPTH_LOG2(2)) dut_s (
    .clk(clk), .reset(rst),
    .inst_sram_en(s_en), .inst_sram_wen(4'h0), .inst_sram_addr(s_addr),
    .inst_sram_wdata(32'h0), .inst_sram_rdata(s_rdata), .addr_err(s_aerr),
    .load_valid(s_ld_v), .load_data(s_ld_d), .load_last(1'b0),
    .load_ready(s_ld_rdy), .load_done(s_ld_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected summary");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one port cycle and push the model's expected response.
  task automatic acc(input logic e, input logic [3:0] w, input logic [31:0] a,
                     input logic [31:0] d);
    exp_t        x;
    logic [31:0] off, nw;
    int          idx;
    @(negedge clk);
    en = e; wen = w; addr = a; wdata = d;
    x.err = 1'b0; x.rd = last_rd; x.known = last_known;
    if (e) begin
      off = a - BASE;
      if (off < 32'h4000) begin
        idx     = int'(off[13:2]);
        x.known = mdl.exists(idx);
        x.rd    = x.known ? mdl[idx] : 32'h0;
        if (w == 4'hf) begin
          mdl[idx] = d;
        end else if (w != 4'h0) begin
          if (x.known) begin
            nw = mdl[idx];
            for (int i = 0; i < 4; i++) if (w[i]) nw[8*i +: 8] = d[8*i +: 8];
            mdl[idx] = nw;
          end
        end
      end else begin
        x.rd = 32'h0; x.err = 1'b1; x.known = 1'b1;
      end
    end
    last_rd = x.rd; last_known = x.known;
    sbq.push_back(x);
  endtask

  task automatic drain();
    @(negedge clk);
    en = 1'b0; wen = 4'h0;
    repeat (4) @(negedge clk);
    chk("drain", 32'(sbq.size()), 32'd0);
    sbq.delete();
  endtask

  task automatic ld_word(input logic [31:0] d, input logic last);
    @(negedge clk);
    ld_v = 1'b1; ld_d = d; ld_l = last;
    @(posedge clk);
    #1 ld_v = 1'b0; ld_l = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    last_rd = 32'h0; last_known = 1'b1;
  endtask

  always @(posedge clk) begin
    if (sbq.size() > 0) begin
      exp_t x;
      x = sbq.pop_front();
      #1;
      if (x.known) chk("rdata", rdata, x.rd);
      chk("addr_err", 32'(aerr), 32'(x.err));
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; wen = 4'h0; addr = '0; wdata = '0;
    ld_v = 1'b0; ld_d = '0; ld_l = 1'b0;
    s_en = 1'b0; s_addr = '0; s_ld_v = 1'b0; s_ld_d = '0;
    last_rd = 32'h0; last_known = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_aerr", 32'(aerr), 32'd0);
    chk("rst_ready", 32'(ld_rdy), 32'd1);
    chk("rst_done", 32'(ld_done), 32'd0);

    // Partial load, then reset: loading must restart at word 0.
    ld_word(32'hAAAA0000, 1'b0);
    ld_word(32'hAAAA0001, 1'b0);
    do_reset();
    chk("reload_ready", 32'(ld_rdy), 32'd1);
    chk("reload_done", 32'(ld_done), 32'd0);

    // Port requests during LOAD are ignored.
    @(negedge clk); en = 1'b1; wen = 4'hf; addr = BASE + 4; wdata = 32'hDEADDEAD;
    @(negedge clk); en = 1'b0; wen = 4'h0;
    chk("load_en_rdata", rdata, 32'h0);
    chk("load_en_aerr", 32'(aerr), 32'd0);

    ld_word(32'h11111111, 1'b0);
    @(negedge clk);
    chk("mid_ready", 32'(ld_rdy), 32'd1);
    chk("mid_done", 32'(ld_done), 32'd0);
    ld_word(32'h22222222, 1'b0);
    ld_word(32'h33333333, 1'b1);
    @(negedge clk);
    chk("end_done", 32'(ld_done), 32'd1);
    chk("end_ready", 32'(ld_rdy), 32'd0);
    mdl[0] = 32'h11111111; mdl[1] = 32'h22222222; mdl[2] = 32'h33333333;

    acc(1'b1, 4'h0, BASE + 4, 32'h0);
    acc(1'b1, 4'h0, BASE,     32'h0);
    acc(1'b1, 4'h0, BASE + 4, 32'h0);
    acc(1'b1, 4'h0, BASE + 8, 32'h0);
    acc(1'b0, 4'h0, BASE,     32'h0);
    acc(1'b0, 4'h0, BASE,     32'h0);
    acc(1'b1, 4'hf, BASE,     32'h33333333);
    acc(1'b1, 4'h3, BASE,     32'hAABBCCDD);
    acc(1'b1, 4'h0, BASE,     32'h0);
    acc(1'b1, 4'h0, BASE + 32'h4000, 32'h0);
    acc(1'b0, 4'h0, BASE,     32'h0);
    acc(1'b1, 4'hf, BASE + 32'h4000, 32'hFFFFFFFF);
    acc(1'b1, 4'h0, BASE - 4, 32'h0);
    acc(1'b1, 4'hf, BASE + 32'h3FFC, 32'hDEADBEEF);
    acc(1'b1, 4'h0, BASE + 32'h3FFC, 32'h0);
    acc(1'b1, 4'h0, BASE + 6, 32'h0);
    acc(1'b1, 4'h0, BASE,     32'h0);

    for (int n = 0; n < 40; n++) begin
      int          k;
      logic [3:0]  w;
      logic [31:0] a;
      k = int'($urandom_range(0, 3));
      a = BASE + 32'(4 * ((k == 3) ? 4095 : k)) + 32'($urandom_range(0, 3));
      w = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) w = 4'h0;
      acc(($urandom_range(0, 4) != 0), w, a, $urandom);
    end
    drain();

    // Reset from READY returns to LOAD; memory beyond the new image survives.
    do_reset();
    chk("warm_ready", 32'(ld_rdy), 32'd1);
    chk("warm_done", 32'(ld_done), 32'd0);
    chk("warm_rdata", rdata, 32'h0);
    ld_word(32'h5A5A5A5A, 1'b1);
    mdl[0] = 32'h5A5A5A5A;
    @(negedge clk);
    chk("warm_end_done", 32'(ld_done), 32'd1);
    acc(1'b1, 4'h0, BASE,     32'h0);
    acc(1'b1, 4'h0, BASE + 4, 32'h0);
    acc(1'b1, 4'h0, BASE + 8, 32'h0);
    drain();

    // Small instance: loader saturates after 2^DEPTH_LOG2 words.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      s_ld_v = 1'b1; s_ld_d = 32'hC0000000 + 32'(i);
      chk("s_ready", 32'(s_ld_rdy), (i < 4) ? 32'd1 : 32'd0);
      chk("s_done",  32'(s_ld_done), (i < 4) ? 32'd0 : 32'd1);
    end
    @(negedge clk);
    s_ld_v = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      s_en = 1'b1; s_addr = BASE + 32'(4 * k);
      @(negedge clk);
      chk("s_rdata", s_rdata, (k < 4) ? 32'hC0000000 + 32'(k) : 32'h0);
      chk("s_aerr", 32'(s_aerr), (k < 4) ? 32'd0 : 32'd1);
    end
    s_en = 1'b0;
    @(negedge clk);
    chk("s_aerr_clr", 32'(s_aerr), 32'd0);
    chk("s_hold", s_rdata, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
